fetch_pc_ctrl: RTL and testbench

- Next-PC sequencer for the fetch stage of the five-stage MIPS pipeline.
- Every cycle, selects the fetch PC from these sources: sequential, branch/jump, eret, and the exception vector. Drives the fetch PC register's npc/en/req inputs.
- Buffers a redirect that arrives while the pipeline is stalled, and issues the IF/ID flush.
- Flags illegal fetch addresses for the CP0 exception path.

---
 rtl/fetch_pc_ctrl_if.sv | 53 +++++
 rtl/fetch_pc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl_if
// Bundle between the fetch-stage next-PC sequencer and the rest of the
// pipeline (fetch PC register, hazard unit, D-stage branch logic, CP0).
//
// Signals
//   pc         current fetch PC from the fetch PC register
//   stall      hazard-unit stall, fetch must hold
//   br_taken   D-stage branch resolved taken     br_target  branch target
//   jump       D-stage j/jal/jr/jalr             j_target   jump target
//   eret       eret in D stage                   epc        CP0 EPC
//   exc_req    CP0 exception/interrupt request
//   npc        next PC to the fetch register
//   en         fetch register load enable
//   req        exception redirect strobe to the fetch register
//   flush_d    clear the IF/ID register this cycle
//   pend_valid a buffered redirect is held
//   pc_fault   illegal fetch address (AdEL)
//   stall_cnt  consecutive stalled cycles, saturating
//
// Modports
//   master  pipeline side: drives the request inputs, observes the sequencer
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface fetch_pc_ctrl_if;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] j_target;
  logic        eret;
  logic [31:0] epc;
  logic        exc_req;

  logic [31:0] npc;
  logic        en;
  logic        req;
  logic        flush_d;
  logic        pend_valid;
  logic        pc_fault;
  logic [7:0]  stall_cnt;

  modport master (
    output pc, stall, br_taken, br_target, jump, j_target, eret, epc, exc_req,
    input  npc, en, req, flush_d, pend_valid, pc_fault, stall_cnt
  );

  modport slave (
    input  pc, stall, br_taken, br_target, jump, j_target, eret, epc, exc_req,
    output npc, en, req, flush_d, pend_valid, pc_fault, stall_cnt
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
// Next-PC sequencer for the fetch stage of a five-stage MIPS pipeline.
// Each cycle it picks the fetch PC from the sequential path, a branch/jump
// target, the eret return address or the exception vector, and drives the
// fetch PC register's npc/en/req inputs. A redirect that arrives while the
// pipeline is stalled is buffered and issued on the first unstalled cycle.
//
// Ports
//   i_clk     system clock, rising edge
//   i_reset   asynchronous reset, active low
//   io_fetch  fetch_pc_ctrl_if.slave bundle (see interface header)
//
// Parameters
//   RESET_PC  PC presented on npc while in reset
//   EXC_VEC   exception/interrupt handler entry
//   TEXT_LO   lowest legal fetch address
//   TEXT_HI   highest legal fetch address
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
  input logic                  i_clk,
  input logic                  i_reset,
  fetch_pc_ctrl_if.slave       io_fetch
);

  typedef enum logic [0:0] {
    StRun,
    StHold
  } state_e;

  localparam logic [7:0] CntMax = 8'hFF;

  // State registers
  state_e      r_state;
  logic [31:0] r_pend_tgt;
  logic        r_pend_flush;
  logic [7:0]  r_stall_cnt;

  // Next-state values
  state_e      w_state_d;
  logic [31:0] w_pend_tgt_d;
  logic        w_pend_flush_d;
  logic [7:0]  w_stall_cnt_d;

  // Redirect selection
  logic        w_redir;
  logic [31:0] w_rtgt;
  logic        w_rflush;

  // Output values
  logic [31:0] w_npc;
  logic        w_en;
  logic        w_req;
  logic        w_flush;
  logic        w_fault;

  // ---------------------------------------------------------------------------
  // Redirect source select: jump > branch > eret. Only eret flushes IF/ID;
  // branches and jumps keep their delay-slot instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_redir  = io_fetch.jump | io_fetch.br_taken | io_fetch.eret;
    w_rtgt   = '0;
    w_rflush = 1'b0;
    if (io_fetch.jump) begin
      w_rtgt = io_fetch.j_target;
    end else if (io_fetch.br_taken) begin
      w_rtgt = io_fetch.br_target;
    end else if (io_fetch.eret) begin
      w_rtgt   = io_fetch.epc;
      w_rflush = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d      = r_state;
    w_pend_tgt_d   = r_pend_tgt;
    w_pend_flush_d = r_pend_flush;
    w_npc          = io_fetch.pc + 32'd4;
    w_en           = 1'b0;
    w_req          = 1'b0;
    w_flush        = 1'b0;

    if (!i_reset) begin
      // Registers are held by the async reset; only the outputs need forcing.
      w_npc = RESET_PC;
    end else if (io_fetch.exc_req) begin
      // Exception wins over everything and discards any buffered redirect.
      w_req          = 1'b1;
      w_npc          = EXC_VEC;
      w_flush        = 1'b1;
      w_state_d      = StRun;
      w_pend_tgt_d   = '0;
      w_pend_flush_d = 1'b0;
    end else if (io_fetch.stall) begin
      w_npc = io_fetch.pc;
      // Only the first redirect seen during a stall is kept.
      if (r_state == StRun && w_redir) begin
        w_state_d      = StHold;
        w_pend_tgt_d   = w_rtgt;
        w_pend_flush_d = w_rflush;
      end
    end else begin
      w_en = 1'b1;
      unique case (r_state)
        StHold: begin
          // The buffered redirect is older than anything arriving now.
          w_npc     = r_pend_tgt;
          w_flush   = r_pend_flush;
          w_state_d = StRun;
        end
        StRun: begin
          if (w_redir) begin
            w_npc   = w_rtgt;
            w_flush = w_rflush;
          end
        end
        default: begin
          w_state_d = StRun;
        end
      endcase
    end
  end

  // Consecutive-stall counter; any load or exception redirect ends the run.
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (w_en || w_req) begin
      w_stall_cnt_d = '0;
    end else if (i_reset && io_fetch.stall && !io_fetch.exc_req && r_stall_cnt != CntMax) begin
      w_stall_cnt_d = r_stall_cnt + 8'd1;
    end
  end

  // Illegal fetch address: misaligned or outside the text segment.
  always_comb begin
    w_fault = i_reset &
              ((io_fetch.pc[1:0] != 2'b00) | (io_fetch.pc < TEXT_LO) | (io_fetch.pc > TEXT_HI));
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StRun;
      r_pend_tgt   <= '0;
      r_pend_flush <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_pend_tgt   <= w_pend_tgt_d;
      r_pend_flush <= w_pend_flush_d;
      r_stall_cnt  <= w_stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_fetch.npc        = w_npc;
  assign io_fetch.en         = w_en;
  assign io_fetch.req        = w_req;
  assign io_fetch.flush_d    = w_flush;
  assign io_fetch.pend_valid = (r_state == StHold);
  assign io_fetch.pc_fault   = w_fault;
  assign io_fetch.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl
// Self-checking bench for fetch_pc_ctrl: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if u_if ();

  fetch_pc_ctrl #(
    .RESET_PC (RESET_PC),
    .EXC_VEC  (EXC_VEC),
    .TEXT_LO  (TEXT_LO),
    .TEXT_HI  (TEXT_HI)
  ) u_dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .io_fetch (u_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: is a redirect buffered, where to, does it flush, stall run.
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_flush;
  int          m_cnt;
  bit          n_pend;
  logic [31:0] n_tgt;
  bit          n_flush;
  int          n_cnt;

  // Expected outputs for the current inputs
  logic [31:0] e_npc;
  bit          e_en, e_req, e_flush, e_pend, e_fault;
  int          e_cnt;

  function automatic void model_reset();
    m_pend  = 0;
    m_tgt   = '0;
    m_flush = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_eval();
    bit          have;
    logic [31:0] tgt;
    bit          fl;
    have = 0;
    tgt  = '0;
    fl   = 0;
    if (u_if.jump) begin
      have = 1; tgt = u_if.j_target;
    end else if (u_if.br_taken) begin
      have = 1; tgt = u_if.br_target;
    end else if (u_if.eret) begin
      have = 1; tgt = u_if.epc; fl = 1;
    end
    e_npc   = u_if.pc + 32'd4;
    e_en    = 0;
    e_req   = 0;
    e_flush = 0;
    e_pend  = m_pend;
    e_cnt   = m_cnt;
    e_fault = rst_n && ((u_if.pc % 4) != 0 || u_if.pc < TEXT_LO || u_if.pc > TEXT_HI);
    n_pend  = m_pend;
    n_tgt   = m_tgt;
    n_flush = m_flush;
    if (!rst_n) begin
      e_npc  = RESET_PC;
      e_pend = 0;
      e_cnt  = 0;
    end else if (u_if.exc_req) begin
      e_req = 1; e_npc = EXC_VEC; e_flush = 1; n_pend = 0;
    end else if (u_if.stall) begin
      e_npc = u_if.pc;
      if (!m_pend && have) begin
        n_pend = 1; n_tgt = tgt; n_flush = fl;
      end
    end else if (m_pend) begin
      e_en = 1; e_npc = m_tgt; e_flush = m_flush; n_pend = 0;
    end else begin
      e_en = 1;
      if (have) begin
        e_npc = tgt; e_flush = fl;
      end
    end
    if (e_en || e_req) n_cnt = 0;
    else if (u_if.stall) n_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    else n_cnt = m_cnt;
  endfunction

  // One clock: evaluate the model on the current inputs, take the edge,
  // commit the model and step 1 time unit past the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst_n) begin
      m_pend = n_pend; m_tgt = n_tgt; m_flush = n_flush; m_cnt = n_cnt;
    end
    #1;
  endtask

  task automatic drive_idle();
    u_if.pc        = 32'h0000_3000;
    u_if.stall     = 1'b0;
    u_if.br_taken  = 1'b0;
    u_if.br_target = '0;
    u_if.jump      = 1'b0;
    u_if.j_target  = '0;
    u_if.eret      = 1'b0;
    u_if.epc       = '0;
    u_if.exc_req   = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst_n = 1'b0;
    model_reset();
    drive_idle();
    #2;
    got = {u_if.npc, u_if.en, u_if.req, u_if.flush_d, u_if.pend_valid, u_if.pc_fault, 3'b000};
    n_checks++;
    if (got !== {32'h0000_3000, 8'h00}) $display("FAIL reset_outputs got=%h want=%h", got, {32'h0000_3000, 8'h00});
    else n_pass++;
    n_checks++;
    if (u_if.stall_cnt !== 8'd0) $display("FAIL reset_stall_cnt got=%0d want=0", u_if.stall_cnt);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;  // released between edges
  endtask

  task automatic test_sequential();
    drive_idle();
    #3;
    n_checks++;
    if ({u_if.npc, u_if.en, u_if.flush_d} !== {32'h0000_3004, 2'b10})
      $display("FAIL seq_3000 npc=%h en=%b flush=%b want npc=00003004 en=1 flush=0", u_if.npc, u_if.en, u_if.flush_d);
    else n_pass++;
    tick();
    u_if.pc = 32'h0000_6FFC;
    #3;
    n_checks++;
    if ({u_if.npc, u_if.pc_fault} !== {32'h0000_7000, 1'b0})
      $display("FAIL seq_6ffc npc=%h fault=%b want npc=00007000 fault=0", u_if.npc, u_if.pc_fault);
    else n_pass++;
    tick();
    u_if.pc = 32'h0000_7000;
    #3;
    n_checks++;
    if (u_if.pc_fault !== 1'b1) $display("FAIL fault_above_hi got=%b want=1", u_if.pc_fault);
    else n_pass++;
    tick();
    u_if.pc = 32'h0000_3002;
    #3;
    n_checks++;
    if (u_if.pc_fault !== 1'b1) $display("FAIL fault_misaligned got=%b want=1", u_if.pc_fault);
    else n_pass++;
    tick();
    u_if.pc = 32'h0000_2FFC;
    #3;
    n_checks++;
    if (u_if.pc_fault !== 1'b1) $display("FAIL fault_below_lo got=%b want=1", u_if.pc_fault);
    else n_pass++;
    tick();
    u_if.pc = 32'hFFFF_FFFC;
    #3;
    n_checks++;
    if (u_if.npc !== 32'h0) $display("FAIL seq_wrap npc=%h want=00000000", u_if.npc);
    else n_pass++;
    tick();
    drive_idle();
  endtask

  task automatic test_redirect_priority();
    drive_idle();
    u_if.br_taken = 1'b1; u_if.br_target = 32'h0000_3100;
    u_if.jump = 1'b1;     u_if.j_target  = 32'h0000_3200;
    u_if.eret = 1'b1;     u_if.epc       = 32'h0000_3300;
    #3;
    n_checks++;
    if ({u_if.npc, u_if.en, u_if.flush_d} !== {32'h0000_3200, 2'b10})
      $display("FAIL jump_over_branch npc=%h en=%b flush=%b want 00003200/1/0", u_if.npc, u_if.en, u_if.flush_d);
    else n_pass++;
    tick();
    u_if.jump = 1'b0;
    #3;
    n_checks++;
    if ({u_if.npc, u_if.flush_d} !== {32'h0000_3100, 1'b0})
      $display("FAIL branch_over_eret npc=%h flush=%b want 00003100/0", u_if.npc, u_if.flush_d);
    else n_pass++;
    tick();
    u_if.br_taken = 1'b0;
    #3;
    n_checks++;
    if ({u_if.npc, u_if.flush_d} !== {32'h0000_3300, 1'b1})
      $display("FAIL eret_flush npc=%h flush=%b want 00003300/1", u_if.npc, u_if.flush_d);
    else n_pass++;
    tick();
    drive_idle();
  endtask

  task automatic test_hold();
    drive_idle();
    u_if.stall = 1'b1; u_if.eret = 1'b1; u_if.epc = 32'h0000_3040;
    #3;
    n_checks++;
    if ({u_if.en, u_if.req, u_if.pend_valid} !== 3'b000)
      $display("FAIL hold_c1 en=%b req=%b pend=%b want 0/0/0", u_if.en, u_if.req, u_if.pend_valid);
    else n_pass++;
    tick();
    u_if.eret = 1'b0; u_if.br_taken = 1'b1; u_if.br_target = 32'h0000_3100;
    #3;
    n_checks++;
    if ({u_if.en, u_if.pend_valid, u_if.stall_cnt} !== {2'b01, 8'd1})
      $display("FAIL hold_c2 en=%b pend=%b cnt=%0d want 0/1/1", u_if.en, u_if.pend_valid, u_if.stall_cnt);
    else n_pass++;
    tick();
    u_if.br_taken = 1'b0;
    #3;
    n_checks++;
    if ({u_if.en, u_if.pend_valid, u_if.stall_cnt} !== {2'b01, 8'd2})
      $display("FAIL hold_c3 en=%b pend=%b cnt=%0d want 0/1/2", u_if.en, u_if.pend_valid, u_if.stall_cnt);
    else n_pass++;
    tick();
    u_if.stall = 1'b0;
    #3;
    n_checks++;
    if ({u_if.npc, u_if.en, u_if.flush_d, u_if.stall_cnt} !== {32'h0000_3040, 2'b11, 8'd3})
      $display("FAIL hold_release npc=%h en=%b flush=%b cnt=%0d want 00003040/1/1/3",
               u_if.npc, u_if.en, u_if.flush_d, u_if.stall_cnt);
    else n_pass++;
    tick();
    #3;
    n_checks++;
    if ({u_if.pend_valid, u_if.stall_cnt, u_if.npc} !== {1'b0, 8'd0, 32'h0000_3004})
      $display("FAIL hold_after pend=%b cnt=%0d npc=%h want 0/0/00003004", u_if.pend_valid, u_if.stall_cnt, u_if.npc);
    else n_pass++;
    tick();
  endtask

  task automatic test_exc_in_hold();
    drive_idle();
    u_if.stall = 1'b1; u_if.eret = 1'b1; u_if.epc = 32'h0000_3080;
    tick();
    u_if.eret = 1'b0; u_if.exc_req = 1'b1;
    #3;
    n_checks++;
    if ({u_if.pend_valid, u_if.req, u_if.en, u_if.flush_d, u_if.npc} !== {4'b1101, 32'h0000_4180})
      $display("FAIL exc_in_hold pend=%b req=%b en=%b flush=%b npc=%h want 1/1/0/1/00004180",
               u_if.pend_valid, u_if.req, u_if.en, u_if.flush_d, u_if.npc);
    else n_pass++;
    tick();
    u_if.exc_req = 1'b0; u_if.stall = 1'b0;
    #3;
    n_checks++;
    if ({u_if.pend_valid, u_if.npc, u_if.flush_d} !== {1'b0, 32'h0000_3004, 1'b0})
      $display("FAIL exc_discard pend=%b npc=%h flush=%b want 0/00003004/0", u_if.pend_valid, u_if.npc, u_if.flush_d);
    else n_pass++;
    tick();
  endtask

  task automatic test_saturate();
    drive_idle();
    u_if.stall = 1'b1;
    repeat (254) tick();
    #3;
    n_checks++;
    if (u_if.stall_cnt !== 8'd254) $display("FAIL cnt_254 got=%0d want=254", u_if.stall_cnt);
    else n_pass++;
    repeat (46) tick();
    #3;
    n_checks++;
    if (u_if.stall_cnt !== 8'd255) $display("FAIL cnt_saturate got=%0d want=255", u_if.stall_cnt);
    else n_pass++;
    u_if.stall = 1'b0;
    #1;
    n_checks++;
    if (u_if.en !== 1'b1) $display("FAIL cnt_release_en got=%b want=1", u_if.en);
    else n_pass++;
    tick();
    #3;
    n_checks++;
    if (u_if.stall_cnt !== 8'd0) $display("FAIL cnt_clear got=%0d want=0", u_if.stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    drive_idle();
    u_if.stall = 1'b1; u_if.jump = 1'b1; u_if.j_target = 32'h0000_3300;
    tick();
    u_if.jump = 1'b0;
    #2;
    n_checks++;
    if (u_if.pend_valid !== 1'b1) $display("FAIL areset_pre pend=%b want=1", u_if.pend_valid);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({u_if.pend_valid, u_if.npc} !== {1'b0, 32'h0000_3000})
      $display("FAIL areset_now pend=%b npc=%h want 0/00003000", u_if.pend_valid, u_if.npc);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    u_if.stall = 1'b0;
    #3;
    n_checks++;
    if ({u_if.pend_valid, u_if.en, u_if.npc} !== {2'b01, 32'h0000_3004})
      $display("FAIL areset_resume pend=%b en=%b npc=%h want 0/1/00003004", u_if.pend_valid, u_if.en, u_if.npc);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    drive_idle();
    for (int i = 0; i < 500; i++) begin
      u_if.stall     = ($urandom_range(0, 99) < 40);
      u_if.jump      = ($urandom_range(0, 99) < 15);
      u_if.br_taken  = ($urandom_range(0, 99) < 20);
      u_if.eret      = ($urandom_range(0, 99) < 15);
      u_if.exc_req   = ($urandom_range(0, 99) < 5);
      u_if.j_target  = $urandom;
      u_if.br_target = $urandom;
      u_if.epc       = $urandom;
      if ($urandom_range(0, 3) != 0) u_if.pc = TEXT_LO + ($urandom_range(0, 32'h0FFF) << 2);
      else u_if.pc = $urandom;
      #3;
      model_eval();
      n_checks++;
      if ({u_if.npc, u_if.en, u_if.req, u_if.flush_d, u_if.pend_valid, u_if.pc_fault, u_if.stall_cnt}
          !== {e_npc, e_en, e_req, e_flush, e_pend, e_fault, e_cnt[7:0]}) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d got npc=%h en=%b req=%b fl=%b pend=%b flt=%b cnt=%0d want npc=%h en=%b req=%b fl=%b pend=%b flt=%b cnt=%0d",
                   i, u_if.npc, u_if.en, u_if.req, u_if.flush_d, u_if.pend_valid, u_if.pc_fault,
                   u_if.stall_cnt, e_npc, e_en, e_req, e_flush, e_pend, e_fault, e_cnt);
        errs++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_priority();
    test_hold();
    test_exc_in_hold();
    test_saturate();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
